// File: rtl/post_pkg.sv
// Shared types for the PostSys sequencer: opcodes, FSM states and instruction field layout.
package post_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MARK  = 3'd1,
    OP_ERASE = 3'd2,
    OP_LEFT  = 3'd3,
    OP_RIGHT = 3'd4,
    OP_JM    = 3'd5,
    OP_JB    = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt,
    StErr
  } state_e;

  localparam int unsigned InstrW = 8;
  localparam int unsigned OpMsb  = 7;
  localparam int unsigned OpLsb  = 5;

  function automatic opcode_e get_op(input logic [InstrW-1:0] instr);
    return opcode_e'(instr[OpMsb:OpLsb]);
  endfunction

endpackage

// File: rtl/post_head_unit.sv
// Tape head register with load/left/right moves and edge detection.
// PMC_TAPE_WRAP_EN makes the head wrap modulo the tape size instead of flagging bound_err_o.
module post_head_unit #(
  parameter int unsigned TAPE_AW   = 5,
  parameter int unsigned HEAD_INIT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               left_i,
  input  logic               right_i,
  output logic [TAPE_AW-1:0] head_o,
  output logic               bound_err_o
);

  localparam logic [TAPE_AW-1:0] HeadInit = TAPE_AW'(HEAD_INIT);
  localparam logic [TAPE_AW-1:0] HeadMax  = '1;
  localparam logic [TAPE_AW-1:0] HeadOne  = TAPE_AW'(1);

  logic [TAPE_AW-1:0] head_q, head_d;

  always_comb begin
    head_d      = head_q;
    bound_err_o = 1'b0;
    if (load_i) begin
      head_d = HeadInit;
    end else if (left_i) begin
`ifdef PMC_TAPE_WRAP_EN
      head_d = head_q - HeadOne;
`else
      if (head_q == '0) bound_err_o = 1'b1;
      else              head_d      = head_q - HeadOne;
`endif
    end else if (right_i) begin
`ifdef PMC_TAPE_WRAP_EN
      head_d = head_q + HeadOne;
`else
      if (head_q == HeadMax) bound_err_o = 1'b1;
      else                   head_d      = head_q + HeadOne;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) head_q <= HeadInit;
    else       head_q <= head_d;
  end

  assign head_o = head_q;

endmodule

// File: rtl/post_machine_ctrl.sv
// Post-Turing machine sequencer: FETCH/DECODE/EXEC over a sync program ROM and a 1-bit tape.
// Build option PMC_TAPE_WRAP_EN (in post_head_unit) turns head bound errors into wrap-around.
module post_machine_ctrl
  import post_pkg::*;
#(
  parameter int unsigned PROG_AW   = 5,
  parameter int unsigned TAPE_AW   = 5,
  parameter int unsigned HEAD_INIT = 16,
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic [PROG_AW-1:0] prog_addr_o,
  input  logic [7:0]         prog_data_i,
  output logic [TAPE_AW-1:0] tape_addr_o,
  input  logic               tape_rd_i,
  output logic               tape_we_o,
  output logic               tape_wd_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic               error_o,
  output logic [PROG_AW-1:0] pc_o,
  output logic [STEP_W-1:0]  steps_o
);

  localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(MAX_STEPS);

  state_e              state_q, state_d;
  logic [PROG_AW-1:0]  pc_q, pc_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [InstrW-1:0]   ir_q, ir_d;
  logic [TAPE_AW-1:0]  head;
  logic                head_load, head_left, head_right, bound_err;
  logic                wr_en, wr_val;
  opcode_e             op;

  assign op = get_op(ir_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    steps_d    = steps_q;
    ir_d       = ir_q;
    head_load  = 1'b0;
    head_left  = 1'b0;
    head_right = 1'b0;
    wr_en      = 1'b0;
    wr_val     = 1'b0;
    case (state_q)
      StIdle, StHalt, StErr: begin
        if (start_i) begin
          state_d   = StFetch;
          pc_d      = '0;
          steps_d   = '0;
          head_load = 1'b1;
        end
      end
      StFetch:  state_d = StDecode;
      StDecode: begin
        ir_d    = prog_data_i;
        state_d = StExec;
      end
      StExec: begin
        steps_d = steps_q + STEP_W'(1);
        pc_d    = pc_q + PROG_AW'(1);
        state_d = StFetch;
        case (op)
          OP_NOP:   ;
          OP_MARK:  begin wr_en = 1'b1; wr_val = 1'b1; end
          OP_ERASE: wr_en = 1'b1;
          OP_LEFT:  head_left = 1'b1;
          OP_RIGHT: head_right = 1'b1;
          OP_JM:    if (tape_rd_i)  pc_d = ir_q[PROG_AW-1:0];
          OP_JB:    if (!tape_rd_i) pc_d = ir_q[PROG_AW-1:0];
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
        endcase
        // A blocked head move leaves pc on the faulting instruction.
        if (bound_err) begin
          pc_d    = pc_q;
          state_d = StErr;
        end else if (op != OP_HALT && steps_d == MaxSteps) begin
          state_d = StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      steps_q <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      steps_q <= steps_d;
      ir_q    <= ir_d;
    end
  end

  post_head_unit #(
    .TAPE_AW   (TAPE_AW),
    .HEAD_INIT (HEAD_INIT)
  ) u_head (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (head_load),
    .left_i      (head_left),
    .right_i     (head_right),
    .head_o      (head),
    .bound_err_o (bound_err)
  );

  // Reset gates the strobe so a write in flight never lands on the tape.
  assign tape_we_o   = wr_en & ~rst_i;
  assign tape_wd_o   = wr_val & ~rst_i;
  assign tape_addr_o = head;
  assign prog_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign steps_o     = steps_q;
  assign busy_o      = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
  assign halted_o    = (state_q == StHalt);
  assign error_o     = (state_q == StErr);

endmodule

// File: tb/tb_post_machine_ctrl.sv
// Directed bench for post_machine_ctrl with behavioural program ROM and tape memory.
module tb_post_machine_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] tape_addr;
  logic       tape_rd;
  logic       tape_we;
  logic       tape_wd;
  logic       busy;
  logic       halted;
  logic       error;
  logic [4:0] pc;
  logic [7:0] steps;

  logic [7:0] prog_mem [32];
  logic       tape_mem [32];
  logic       tape_clr = 1'b0;
  int         we_count = 0;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= prog_mem[prog_addr];

  always @(posedge clk) begin
    if (tape_clr) begin
      for (int i = 0; i < 32; i++) tape_mem[i] <= 1'b0;
    end else if (tape_we) begin
      tape_mem[tape_addr] <= tape_wd;
      we_count <= we_count + 1;
    end
  end

  assign tape_rd = tape_mem[tape_addr];

  post_machine_ctrl #(
    .PROG_AW   (5),
    .TAPE_AW   (5),
    .HEAD_INIT (16),
    .STEP_W    (8),
    .MAX_STEPS (255)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .prog_addr_o (prog_addr),
    .prog_data_i (prog_data),
    .tape_addr_o (tape_addr),
    .tape_rd_i   (tape_rd),
    .tape_we_o   (tape_we),
    .tape_wd_o   (tape_wd),
    .busy_o      (busy),
    .halted_o    (halted),
    .error_o     (error),
    .pc_o        (pc),
    .steps_o     (steps)
  );

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog_mem[i] = 8'h00;
  endtask

  task automatic clear_tape();
    tape_clr = 1'b1;
    @(negedge clk);
    tape_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the bench at the negedge right after the edge that samples start.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, halted, error, tape_we, tape_wd} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, halted, error, tape_we, tape_wd});
    end
    checks++;
    if (pc !== 5'd0 || prog_addr !== 5'd0 || steps !== 8'd0) begin
      failures++;
      $display("FAIL reset_counters got pc=%0d addr=%0d steps=%0d exp 0/0/0", pc, prog_addr, steps);
    end
    checks++;
    if (tape_addr !== 5'd16) begin
      failures++;
      $display("FAIL reset_head got=%0d exp=16", tape_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mark_right();
    int we0;
    clear_prog();
    prog_mem[0] = 8'h20; // MARK
    prog_mem[1] = 8'h80; // RIGHT
    prog_mem[2] = 8'h20; // MARK
    prog_mem[3] = 8'hE0; // HALT
    clear_tape();
    we0 = we_count;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mr_busy_after_start got=%b exp=1", busy);
    end
    repeat (11) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      failures++;
      $display("FAIL mr_before_halt got busy=%b halted=%b exp 1/0", busy, halted);
    end
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL mr_halt got h=%b b=%b e=%b exp 1/0/0", halted, busy, error);
    end
    checks++;
    if (tape_mem[16] !== 1'b1 || tape_mem[17] !== 1'b1) begin
      failures++;
      $display("FAIL mr_tape got t16=%b t17=%b exp 1/1", tape_mem[16], tape_mem[17]);
    end
    checks++;
    if (tape_addr !== 5'd17 || steps !== 8'd4 || pc !== 5'd3) begin
      failures++;
      $display("FAIL mr_state got head=%0d steps=%0d pc=%0d exp 17/4/3", tape_addr, steps, pc);
    end
    checks++;
    if (we_count - we0 !== 2) begin
      failures++;
      $display("FAIL mr_writes got=%0d exp=2", we_count - we0);
    end
  endtask

  task automatic test_restart();
    clear_prog();
    prog_mem[0] = 8'hE0; // HALT
    pulse_start();
    checks++;
    if (busy !== 1'b1 || pc !== 5'd0 || steps !== 8'd0 || tape_addr !== 5'd16) begin
      failures++;
      $display("FAIL restart_init got b=%b pc=%0d steps=%0d head=%0d exp 1/0/0/16",
               busy, pc, steps, tape_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || steps !== 8'd1 || pc !== 5'd0) begin
      failures++;
      $display("FAIL restart_halt got h=%b steps=%0d pc=%0d exp 1/1/0", halted, steps, pc);
    end
    checks++;
    if (tape_mem[16] !== 1'b1 || tape_mem[17] !== 1'b1) begin
      failures++;
      $display("FAIL restart_tape_kept got t16=%b t17=%b exp 1/1", tape_mem[16], tape_mem[17]);
    end
  endtask

  task automatic test_jumps();
    logic [4:0] path [4];
    path[0] = 5'd0; path[1] = 5'd3; path[2] = 5'd4; path[3] = 5'd2;
    clear_prog();
    prog_mem[0] = 8'hC3; // JB 3
    prog_mem[1] = 8'h00; // NOP
    prog_mem[2] = 8'hE0; // HALT
    prog_mem[3] = 8'h20; // MARK
    prog_mem[4] = 8'hA2; // JM 2
    clear_tape();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pc !== path[i] || busy !== 1'b1) begin
        failures++;
        $display("FAIL jump_path[%0d] got pc=%0d busy=%b exp pc=%0d busy=1", i, pc, busy, path[i]);
      end
      repeat (3) @(negedge clk);
    end
    checks++;
    if (halted !== 1'b1 || pc !== 5'd2 || steps !== 8'd4 || tape_mem[16] !== 1'b1) begin
      failures++;
      $display("FAIL jump_end got h=%b pc=%0d steps=%0d t16=%b exp 1/2/4/1",
               halted, pc, steps, tape_mem[16]);
    end
  endtask

  task automatic test_bound_left();
    int we0;
    clear_prog();
    for (int i = 0; i < 17; i++) prog_mem[i] = 8'h60; // LEFT
    we0 = we_count;
    pulse_start();
    repeat (48) @(negedge clk);
    checks++;
    if (tape_addr !== 5'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL left_walk got head=%0d busy=%b exp 0/1", tape_addr, busy);
    end
    repeat (3) @(negedge clk);
`ifdef PMC_TAPE_WRAP_EN
    checks++;
    if (tape_addr !== 5'd31 || busy !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL left_wrap got head=%0d busy=%b err=%b exp 31/1/0", tape_addr, busy, error);
    end
`else
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || tape_addr !== 5'd0 || steps !== 8'd17) begin
      failures++;
      $display("FAIL left_bound got err=%b busy=%b head=%0d steps=%0d exp 1/0/0/17",
               error, busy, tape_addr, steps);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || halted !== 1'b0 || steps !== 8'd17) begin
      failures++;
      $display("FAIL left_hold got err=%b halted=%b steps=%0d exp 1/0/17", error, halted, steps);
    end
`endif
    checks++;
    if (we_count - we0 !== 0) begin
      failures++;
      $display("FAIL left_nowrite got=%0d exp=0", we_count - we0);
    end
  endtask

  task automatic test_bound_right();
    clear_prog();
    for (int i = 0; i < 16; i++) prog_mem[i] = 8'h80; // RIGHT
    pulse_start();
    repeat (45) @(negedge clk);
    checks++;
    if (tape_addr !== 5'd31 || busy !== 1'b1) begin
      failures++;
      $display("FAIL right_walk got head=%0d busy=%b exp 31/1", tape_addr, busy);
    end
    repeat (3) @(negedge clk);
`ifdef PMC_TAPE_WRAP_EN
    checks++;
    if (tape_addr !== 5'd0 || busy !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL right_wrap got head=%0d busy=%b err=%b exp 0/1/0", tape_addr, busy, error);
    end
`else
    checks++;
    if (error !== 1'b1 || tape_addr !== 5'd31 || steps !== 8'd16) begin
      failures++;
      $display("FAIL right_bound got err=%b head=%0d steps=%0d exp 1/31/16", error, tape_addr, steps);
    end
`endif
  endtask

  task automatic test_watchdog();
    int bc;
    int guard;
    do_reset();
    clear_prog();
    prog_mem[0] = 8'hC0; // JB 0
    clear_tape();
    pulse_start();
    bc = 0;
    guard = 0;
    while (busy && guard < 2000) begin
      bc++;
      guard++;
      @(negedge clk);
    end
    checks++;
    if (error !== 1'b1 || steps !== 8'd255 || bc !== 765) begin
      failures++;
      $display("FAIL watchdog got err=%b steps=%0d busy_cycles=%0d exp 1/255/765", error, steps, bc);
    end
  endtask

  task automatic test_rst_mid();
    int we0;
    do_reset();
    clear_prog();
    prog_mem[0] = 8'h20; // MARK
    prog_mem[1] = 8'hE0; // HALT
    clear_tape();
    we0 = we_count;
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if (tape_we !== 1'b1 || tape_wd !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_exec got we=%b wd=%b exp 1/1", tape_we, tape_wd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tape_we !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_we_gated got=%b exp=0", tape_we);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tape_mem[16] !== 1'b0 || we_count - we0 !== 0) begin
      failures++;
      $display("FAIL rstmid_nowrite got t16=%b writes=%0d exp 0/0", tape_mem[16], we_count - we0);
    end
    checks++;
    if ({busy, halted, error, tape_we} !== 4'b0 || pc !== 5'd0 || steps !== 8'd0 ||
        tape_addr !== 5'd16) begin
      failures++;
      $display("FAIL rstmid_state got flags=%b pc=%0d steps=%0d head=%0d exp 0000/0/0/16",
               {busy, halted, error, tape_we}, pc, steps, tape_addr);
    end
  endtask

  task automatic test_start_busy();
    clear_prog();
    prog_mem[3] = 8'hE0; // NOP, NOP, NOP, HALT
    @(negedge clk);
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    checks++;
    if (pc !== 5'd1 || steps !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy got pc=%0d steps=%0d busy=%b exp 1/1/1", pc, steps, busy);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || pc !== 5'd3 || steps !== 8'd4) begin
      failures++;
      $display("FAIL start_busy_end got h=%b pc=%0d steps=%0d exp 1/3/4", halted, pc, steps);
    end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_mark_right();
    test_restart();
    test_jumps();
    test_bound_left();
    test_bound_right();
    test_watchdog();
    test_rst_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/post_machine_ctrl.md
Name: post_machine_ctrl

Overview:
Sequencer for the PostSys Post-Turing machine datapath. Fetches 8-bit instructions from a synchronous program memory and executes them against a 1-bit-per-cell tape memory through a head pointer. Reports busy/halted/error status and the current PC to the top-level tt_um_galaguna_PostSys I/O. Sits between the user-pin control logic and the program/tape storage.

Parameters:
PROG_AW, 5, program address width; instruction target field width equals PROG_AW
TAPE_AW, 5, tape address width (2**TAPE_AW cells)
HEAD_INIT, 16, head position loaded on start
STEP_W, 8, step counter width
MAX_STEPS, 255, watchdog limit on executed instructions; must be below 2**STEP_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin execution from PC 0
prog_addr  out  PROG_AW  program memory read address
prog_data  in  8  program word, valid one cycle after prog_addr is presented
tape_addr  out  TAPE_AW  tape cell address; always equals head
tape_rd  in  1  tape cell value, combinational from tape_addr
tape_we  out  1  tape write strobe, one cycle wide
tape_wd  out  1  tape write data
busy  out  1  high in FETCH/DECODE/EXEC
halted  out  1  high in HALT
error  out  1  high in ERR
pc  out  PROG_AW  current program counter
steps  out  STEP_W  instructions executed since start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: state IDLE, pc=0, head=HEAD_INIT, steps=0, tape_we=0, tape_wd=0, prog_addr=0, busy/halted/error=0.
- Instruction format: [7:5] opcode, [4:0] target. Opcodes: 0 NOP, 1 MARK (write 1), 2 ERASE (write 0), 3 LEFT (head-1), 4 RIGHT (head+1), 5 JM (jump if tape_rd=1), 6 JB (jump if tape_rd=0), 7 HALT.
- FSM IDLE->FETCH on start. FETCH: drive prog_addr=pc. DECODE: latch prog_data into ir. EXEC: perform ir, steps+=1, then FETCH, HALT or ERR. Each instruction takes exactly 3 cycles.
- EXEC updates:
  - MARK and ERASE assert tape_we with tape_wd=1 or 0 for that cycle only.
  - Jumps that are taken set pc=target. All other instructions set pc=pc+1 modulo 2**PROG_AW; execution wraps past the end of program memory.
  - HALT: pc unchanged, go to HALT.
- Head bounds: LEFT at head=0 or RIGHT at head=2**TAPE_AW-1 -> ERR. head is unchanged and no write occurs.
- Watchdog: an EXEC that makes steps reach MAX_STEPS, and is not HALT, -> ERR after that instruction completes.
- HALT and ERR hold all state and are left only by start or rst. start restarts with pc=0, head=HEAD_INIT, steps=0. The tape is not cleared.
- start while busy is ignored.
- rst mid-instruction: any pending write is dropped, and tape_we is 0 from the next edge.

Optional Feature:
Macro PMC_TAPE_WRAP_EN.
- Defined: head moves modulo 2**TAPE_AW; LEFT at 0 -> 2**TAPE_AW-1, RIGHT at max -> 0. No bounds error; the watchdog error remains.
- Undefined: the bounds error behaviour above applies.

Decomposition:
- Package post_pkg: opcode enum (OP_NOP..OP_HALT), FSM state enum, instruction field positions/widths.
- Sub-module post_head_unit: head register with load/left/right controls, bound detection and the PMC_TAPE_WRAP_EN wrap logic. It outputs head and a bound_err flag.

Test Plan:
- Program {MARK, RIGHT, MARK, HALT}, start -> tape[16]=1, tape[17]=1, head=17, halted=1, steps=4, pc=3. Busy goes high 1 cycle after start; halt is reached 12 cycles after FETCH is entered.
- Program {JB 3, NOP, HALT, MARK, JM 2} on a blank tape -> path pc 0,3,4,2; tape[16]=1; steps=4.
- HEAD_INIT=0, program {LEFT} -> error=1, head=0, steps=1, no tape_we. With PMC_TAPE_WRAP_EN: head=31 and execution continues.
- Program {JM 0 ... } with an all-NOP loop, e.g. {JB 0} on a blank cell -> error=1 with steps=255 after 765 busy cycles.
- rst asserted in the EXEC cycle of MARK -> no tape write, all outputs at reset values next cycle. start during busy -> pc and steps unaffected.
- After HALT, pulse start -> pc=0, steps=0, head=HEAD_INIT, tape contents preserved.
